// File: rtl/peg_l2_rs_rmii_rx_framer_pkg.sv
// Shared types for the RMII RX framer: FSM state encoding, preamble/SFD bytes
// and the FIFO entry layout.
package peg_l2_rx_framer_pkg;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic       err;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/peg_l2_rs_rmii_rx_framer_if.sv
// Framed byte stream from the RMII RX framer to MAC RX, with pkt_ready backpressure.
interface peg_l2_rs_rmii_rx_framer_if;
  logic       pkt_valid;
  logic       pkt_sop;
  logic       pkt_eop;
  logic [7:0] pkt_data;
  logic       pkt_error;
  logic       pkt_ready;

  modport master (output pkt_valid, pkt_sop, pkt_eop, pkt_data, pkt_error, input pkt_ready);
  modport slave  (input pkt_valid, pkt_sop, pkt_eop, pkt_data, pkt_error, output pkt_ready);
endinterface

// File: rtl/peg_l2_rs_rmii_rx_framer_fifo.sv
// Synchronous FIFO of framer entries with full, almost-full (one free slot),
// empty and occupancy outputs. A full FIFO accepts a push in a popping cycle.
module peg_l2_rx_frm_fifo
  import peg_l2_rx_framer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     rmii_ref_clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  fifo_entry_t              push_data_i,
  input  logic                     pop_i,
  output fifo_entry_t              head_o,
  output logic                     full_o,
  output logic                     almost_full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  fifo_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          push_ok, pop_ok;

  assign empty_o       = (level_q == '0);
  assign full_o        = (level_q == (AW+1)'(DEPTH));
  assign almost_full_o = (level_q == (AW+1)'(DEPTH - 1));
  assign pop_ok        = pop_i && !empty_o;
  assign push_ok       = push_i && (!full_o || pop_ok);
  assign head_o        = mem_q[rd_ptr_q];
  assign level_o       = level_q;

  always_ff @(posedge rmii_ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge rmii_ref_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/peg_l2_rs_rmii_rx_framer.sv
// RMII RX framer: strips preamble/SFD, delimits frames on carrier loss, tags sop/eop/err.
// Optional length check enabled by PEG_L2_RX_FRAMER_LEN_CHECK_EN.
module peg_l2_rs_rmii_rx_framer
  import peg_l2_rx_framer_pkg::*;
#(
  parameter int PKT_DATA_W      = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int MIN_PREAMBLE    = 5,
  parameter int CRS_END_CYCLES  = 2,
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1522
) (
  input  logic                          rmii_ref_clk,
  input  logic                          rst_n,
  input  logic                          in_valid_i,
  input  logic [PKT_DATA_W-1:0]         in_data_i,
  input  logic                          in_error_i,
  input  logic                          rmii_crs_dv_i,
  peg_l2_rs_rmii_rx_framer_if.master    pkt_if,
  output logic                          stat_frame_ok_o,
  output logic                          stat_frame_err_o,
  output logic                          stat_overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
  localparam int CW = $clog2(CRS_END_CYCLES + 1);
  localparam logic [CW-1:0] CRS_MAX = CW'(CRS_END_CYCLES);

  if (PKT_DATA_W != 8 || FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      MIN_FRAME_BYTES > MAX_FRAME_BYTES) begin : g_bad_param
    $error("peg_l2_rs_rmii_rx_framer: unsupported parameter set");
  end

  state_t        state_q, state_d;
  logic [2:0]    pre_cnt_q, pre_cnt_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_vld_q, hold_vld_d;
  logic          first_q, first_d;
  logic          err_acc_q, err_acc_d;
  logic [CW-1:0] crs_cnt_q, crs_cnt_d;
  logic          cend, pop, push, final_err, last_slot, blocked, len_over, len_bad;
  fifo_entry_t   push_entry, head;
  logic          fifo_full, fifo_afull, fifo_empty;

  // Carrier end only counts in byte-free cycles; a byte in the same cycle defers it.
  assign crs_cnt_d = rmii_crs_dv_i ? '0 : ((crs_cnt_q == CRS_MAX) ? crs_cnt_q : crs_cnt_q + CW'(1));
  assign cend      = !in_valid_i && (crs_cnt_d == CRS_MAX);

  assign pop       = !fifo_empty && pkt_if.pkt_ready;
  assign last_slot = (fifo_afull && !pop) || (fifo_full && pop);
  assign blocked   = fifo_full && !pop;

`ifdef PEG_L2_RX_FRAMER_LEN_CHECK_EN
  logic [10:0] len_q, len_d, len_inc;
  assign len_inc  = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
  assign len_over = len_inc > 11'(MAX_FRAME_BYTES);
  assign len_bad  = (len_q < 11'(MIN_FRAME_BYTES)) || (len_q > 11'(MAX_FRAME_BYTES));
  always_comb begin
    len_d = len_q;
    if (state_q == PREAMBLE)                len_d = '0;
    else if (state_q == DATA && in_valid_i) len_d = len_inc;
  end
  always_ff @(posedge rmii_ref_clk or negedge rst_n) begin
    if (!rst_n) len_q <= '0;
    else        len_q <= len_d;
  end
`else
  assign len_over = 1'b0;
  assign len_bad  = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    pre_cnt_d        = pre_cnt_q;
    hold_d           = hold_q;
    hold_vld_d       = hold_vld_q;
    first_d          = first_q;
    err_acc_d        = err_acc_q;
    push             = 1'b0;
    final_err        = 1'b0;
    push_entry       = '{sop: first_q, eop: 1'b0, err: 1'b0, data: hold_q};
    stat_frame_ok_o  = 1'b0;
    stat_frame_err_o = 1'b0;
    stat_overflow_o  = 1'b0;
    unique case (state_q)
      IDLE: if (in_valid_i) begin
        state_d   = PREAMBLE;
        pre_cnt_d = (in_data_i == PREAMBLE_BYTE) ? 3'd1 : 3'd0;
      end
      PREAMBLE: if (cend) state_d = IDLE;
      else if (in_valid_i) begin
        if (in_data_i == PREAMBLE_BYTE) begin
          pre_cnt_d = (pre_cnt_q == 3'd7) ? 3'd7 : pre_cnt_q + 3'd1;
        end else if (in_data_i == SFD_BYTE && pre_cnt_q >= 3'(MIN_PREAMBLE)) begin
          state_d    = DATA;
          hold_vld_d = 1'b0;
          first_d    = 1'b1;
          err_acc_d  = 1'b0;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        err_acc_d = err_acc_q | in_error_i;
        if (cend) begin
          state_d    = IDLE;
          hold_vld_d = 1'b0;
          final_err  = err_acc_d | len_bad;
          if (hold_vld_q && blocked) begin
            stat_overflow_o = 1'b1;
          end else if (hold_vld_q) begin
            push             = 1'b1;
            push_entry.eop   = 1'b1;
            push_entry.err   = final_err;
            stat_frame_ok_o  = !final_err;
            stat_frame_err_o = final_err;
          end
        end else if (in_valid_i) begin
          hold_d     = in_data_i;
          hold_vld_d = 1'b1;
          if (hold_vld_q) begin
            // Truncate on the last free slot (or over-length) so the frame still gets its eop.
            if (blocked) begin
              state_d         = DROP;
              hold_vld_d      = 1'b0;
              stat_overflow_o = 1'b1;
            end else if (last_slot || len_over) begin
              push             = 1'b1;
              push_entry.eop   = 1'b1;
              push_entry.err   = 1'b1;
              stat_frame_err_o = 1'b1;
              stat_overflow_o  = last_slot;
              state_d          = DROP;
              hold_vld_d       = 1'b0;
            end else begin
              push = 1'b1;
            end
          end
        end
      end
      DROP: if (cend) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (push) first_d = 1'b0;
  end

  always_ff @(posedge rmii_ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pre_cnt_q  <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      first_q    <= 1'b0;
      err_acc_q  <= 1'b0;
      crs_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      first_q    <= first_d;
      err_acc_q  <= err_acc_d;
      crs_cnt_q  <= crs_cnt_d;
    end
  end

  peg_l2_rx_frm_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .rmii_ref_clk  (rmii_ref_clk),
    .rst_n         (rst_n),
    .push_i        (push),
    .push_data_i   (push_entry),
    .pop_i         (pop),
    .head_o        (head),
    .full_o        (fifo_full),
    .almost_full_o (fifo_afull),
    .empty_o       (fifo_empty),
    .level_o       (fifo_level_o)
  );

  assign pkt_if.pkt_valid = !fifo_empty;
  assign pkt_if.pkt_sop   = head.sop & !fifo_empty;
  assign pkt_if.pkt_eop   = head.eop & !fifo_empty;
  assign pkt_if.pkt_error = head.err & !fifo_empty;
  assign pkt_if.pkt_data  = fifo_empty ? '0 : head.data;
endmodule

// File: tb/tb_peg_l2_rs_rmii_rx_framer.sv
// Directed bench for the RMII RX framer: good, errored, short-preamble, overflow,
// throttled and reset-interrupted frames checked against hand-computed streams.
module tb_peg_l2_rs_rmii_rx_framer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_error = 1'b0, crs_dv = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       rdy = 1'b0, tog = 1'b0, tog_en = 1'b0;
  logic       stat_ok, stat_err, stat_ovf;
  logic [4:0] level;
  int         passed = 0, total = 0;
  int         n_ok = 0, n_err = 0, n_ovf = 0, max_lvl = 0;
  int         ok0, err0, ovf0, rd_idx = 0;
  logic [10:0] got[$];

  peg_l2_rs_rmii_rx_framer_if pkt_if();

  peg_l2_rs_rmii_rx_framer dut (
    .rmii_ref_clk     (clk),
    .rst_n            (rst_n),
    .in_valid_i       (in_valid),
    .in_data_i        (in_data),
    .in_error_i       (in_error),
    .rmii_crs_dv_i    (crs_dv),
    .pkt_if           (pkt_if),
    .stat_frame_ok_o  (stat_ok),
    .stat_frame_err_o (stat_err),
    .stat_overflow_o  (stat_ovf),
    .fifo_level_o     (level)
  );

  assign pkt_if.pkt_ready = tog_en ? tog : rdy;

  always #10 clk = ~clk;
  always @(posedge clk) #1 tog = ~tog;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pkt_if.pkt_valid && pkt_if.pkt_ready)
        got.push_back({pkt_if.pkt_sop, pkt_if.pkt_eop, pkt_if.pkt_error, pkt_if.pkt_data});
      n_ok  += int'(stat_ok);
      n_err += int'(stat_err);
      n_ovf += int'(stat_ovf);
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic send_byte(logic [7:0] d, logic e, int gap);
    in_valid = 1'b1; crs_dv = 1'b1; in_data = d; in_error = e;
    tick();
    in_valid = 1'b0; in_error = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_frame(int npre, int n, logic [7:0] base, int err_idx, int gap);
    for (int i = 0; i < npre; i++) send_byte(8'h55, 1'b0, gap);
    send_byte(8'hD5, 1'b0, gap);
    for (int i = 0; i < n; i++) send_byte(base + 8'(i), i == err_idx, gap);
  endtask

  task automatic end_frame();
    in_valid = 1'b0; crs_dv = 1'b0;
    repeat (4) tick();
  endtask

  task automatic snap();
    ok0 = n_ok; err0 = n_err; ovf0 = n_ovf;
  endtask

  // Expected stream: base, base+1, ...; sop on the first, eop (with last_err) on the last.
  task automatic check_frame(string tag, int n, logic [7:0] base, logic last_err);
    chk({tag, " len"}, got.size() - rd_idx, n);
    for (int i = 0; i < n && rd_idx + i < got.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), {21'd0, got[rd_idx + i]},
          {21'd0, 1'(i == 0), 1'(i == n - 1), 1'((i == n - 1) && last_err), base + 8'(i)});
    rd_idx = got.size();
  endtask

  initial begin
    repeat (2) tick();
    chk("rst valid", pkt_if.pkt_valid, 0);
    chk("rst level", level, 0);
    chk("rst data", {pkt_if.pkt_sop, pkt_if.pkt_eop, pkt_if.pkt_error, pkt_if.pkt_data}, 0);
    chk("rst stats", {stat_ok, stat_err, stat_ovf}, 0);
    rst_n = 1'b1;
    rdy = 1'b1;
    repeat (3) tick();

    snap();
    send_frame(7, 64, 8'h00, -1, 0);
    end_frame();
    repeat (4) tick();
    check_frame("t1", 64, 8'h00, 1'b0);
    chk("t1 ok", n_ok - ok0, 1);
    chk("t1 err", n_err - err0, 0);

    snap();
    send_frame(7, 64, 8'h00, 10, 0);
    end_frame();
    repeat (4) tick();
    check_frame("t2", 64, 8'h00, 1'b1);
    chk("t2 ok", n_ok - ok0, 0);
    chk("t2 err", n_err - err0, 1);

    snap();
    send_frame(3, 20, 8'h80, -1, 0);
    end_frame();
    repeat (4) tick();
    chk("t3 dropped", got.size() - rd_idx, 0);
    chk("t3 stats", (n_ok - ok0) + (n_err - err0) + (n_ovf - ovf0), 0);
    send_frame(7, 64, 8'h40, -1, 0);
    end_frame();
    repeat (4) tick();
    check_frame("t3 next", 64, 8'h40, 1'b0);
    chk("t3 next ok", n_ok - ok0, 1);

    snap();
    rdy = 1'b0;
    send_frame(7, 40, 8'h00, -1, 0);
    end_frame();
    chk("t4 level", level, 16);
    chk("t4 ovf", n_ovf - ovf0, 1);
    rdy = 1'b1;
    repeat (20) tick();
    check_frame("t4", 16, 8'h00, 1'b1);
    chk("t4 drained", level, 0);
    snap();
    send_frame(7, 64, 8'h20, -1, 0);
    end_frame();
    repeat (4) tick();
    check_frame("t4 next", 64, 8'h20, 1'b0);
    chk("t4 next ok", n_ok - ok0, 1);

    snap();
    tog_en = 1'b1;
    send_frame(7, 64, 8'hA0, -1, 3);
    end_frame();
    tog_en = 1'b0;
    repeat (6) tick();
    check_frame("t5", 64, 8'hA0, 1'b0);
    chk("t5 ok", n_ok - ok0, 1);
    chk("t5 ovf", n_ovf - ovf0, 0);
    chk("t5 max level", max_lvl <= 16, 1);

    rdy = 1'b0;
    send_frame(7, 10, 8'h00, -1, 0);
    chk("t6 level pre", level, 9);
    rst_n = 1'b0;
    tick();
    chk("t6 valid", pkt_if.pkt_valid, 0);
    chk("t6 level", level, 0);
    rst_n = 1'b1;
    end_frame();
    rdy = 1'b1;
    repeat (4) tick();
    chk("t6 no resume", got.size() - rd_idx, 0);
    snap();
    send_frame(7, 64, 8'h10, -1, 0);
    end_frame();
    repeat (4) tick();
    check_frame("t6 next", 64, 8'h10, 1'b0);
    chk("t6 next ok", n_ok - ok0, 1);

`ifdef PEG_L2_RX_FRAMER_LEN_CHECK_EN
    snap();
    send_frame(7, 60, 8'h00, -1, 0);
    end_frame();
    repeat (4) tick();
    check_frame("len60", 60, 8'h00, 1'b1);
    chk("len60 err", n_err - err0, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
